// File: rtl/csi_tx_phy_dat_seq.sv
// Transmit-side sequencer for one MIPI D-PHY HS data lane: LP entry, HS-zero, sync, payload, trail, LP exit.
// Define CSI_TX_BURST_STATS_EN to add the burst_cnt / last_len statistics outputs.
module csi_tx_phy_dat_seq #(
  parameter bit         INVERT    = 1'b0,
  parameter logic [7:0] T_LPX     = 8'd4,
  parameter logic [7:0] T_PREPARE = 8'd4,
  parameter logic [7:0] T_ZERO    = 8'd10,
  parameter logic [7:0] T_TRAIL   = 8'd4,
  parameter logic [7:0] T_EXIT    = 8'd8
) (
  input  logic        byte_clock,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic [7:0]  hs_byte,
  output logic        hs_oe,
  output logic        lp_p,
  output logic        lp_n,
  output logic        busy,
  output logic        underrun
`ifdef CSI_TX_BURST_STATS_EN
  ,
  output logic [15:0] burst_cnt,
  output logic [15:0] last_len
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_LPX, S_PREP, S_ZERO, S_SYNC, S_DATA, S_TRAIL, S_EXIT
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hB8;
  localparam logic [7:0] HS_MASK   = {8{INVERT}};

  // Counter load values: a state lasts load+1 cycles, so a zero parameter still gives one cycle.
  localparam logic [7:0] LD_LPX   = (T_LPX     == 8'd0) ? 8'd0 : T_LPX     - 8'd1;
  localparam logic [7:0] LD_PREP  = (T_PREPARE == 8'd0) ? 8'd0 : T_PREPARE - 8'd1;
  localparam logic [7:0] LD_ZERO  = (T_ZERO    == 8'd0) ? 8'd0 : T_ZERO    - 8'd1;
  localparam logic [7:0] LD_TRAIL = (T_TRAIL   == 8'd0) ? 8'd0 : T_TRAIL   - 8'd1;
  localparam logic [7:0] LD_EXIT  = (T_EXIT    == 8'd0) ? 8'd0 : T_EXIT    - 8'd1;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] raw_q, raw_d;      // un-inverted lane byte, source of the trail polarity
  logic       trail_q, trail_d;  // trail bit level, ~b7 of the last payload byte
  logic       hs_oe_d;
  logic [1:0] lp_d;
  logic       busy_d;
  logic       underrun_d;

  assign in_ready = (state_q == S_DATA);

  // NOTE: every signal gets a default before the case so no path leaves it unassigned and infers a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    raw_d      = 8'h00;
    trail_d    = trail_q;
    hs_oe_d    = 1'b0;
    lp_d       = 2'b11;
    busy_d     = 1'b1;
    underrun_d = underrun;

    unique case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (in_valid) begin
          state_d = S_LPX;
          cnt_d   = LD_LPX;
        end
      end
      S_LPX: begin
        lp_d = 2'b01;
        if (cnt_q == 8'd0) begin
          state_d = S_PREP;
          cnt_d   = LD_PREP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_PREP: begin
        lp_d = 2'b00;
        if (cnt_q == 8'd0) begin
          state_d = S_ZERO;
          cnt_d   = LD_ZERO;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_ZERO: begin
        lp_d    = 2'b00;
        hs_oe_d = 1'b1;
        if (cnt_q == 8'd0) begin
          state_d = S_SYNC;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_SYNC: begin
        lp_d    = 2'b00;
        hs_oe_d = 1'b1;
        raw_d   = SYNC_BYTE;
        state_d = S_DATA;
      end
      S_DATA: begin
        lp_d    = 2'b00;
        hs_oe_d = 1'b1;
        if (in_valid) begin
          raw_d   = in_data;
          trail_d = ~in_data[7];
          if (in_last) begin
            state_d = S_TRAIL;
            cnt_d   = LD_TRAIL;
          end
        end else begin
          // Starvation: the byte already on the lane becomes the last one and
          // the first trail byte goes out now, so the trail still totals T_TRAIL.
          underrun_d = 1'b1;
          raw_d      = {8{~raw_q[7]}};
          trail_d    = ~raw_q[7];
          if (LD_TRAIL == 8'd0) begin
            state_d = S_EXIT;
            cnt_d   = LD_EXIT;
          end else begin
            state_d = S_TRAIL;
            cnt_d   = LD_TRAIL - 8'd1;
          end
        end
      end
      S_TRAIL: begin
        lp_d    = 2'b00;
        hs_oe_d = 1'b1;
        raw_d   = {8{trail_q}};
        if (cnt_q == 8'd0) begin
          state_d = S_EXIT;
          cnt_d   = LD_EXIT;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_EXIT: begin
        if (cnt_q == 8'd0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge byte_clock) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      raw_q    <= 8'h00;
      trail_q  <= 1'b0;
      hs_byte  <= HS_MASK;
      hs_oe    <= 1'b0;
      lp_p     <= 1'b1;
      lp_n     <= 1'b1;
      busy     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      raw_q    <= raw_d;
      trail_q  <= trail_d;
      hs_byte  <= raw_d ^ HS_MASK;
      hs_oe    <= hs_oe_d;
      lp_p     <= lp_d[1];
      lp_n     <= lp_d[0];
      busy     <= busy_d;
      underrun <= underrun_d;
    end
  end

`ifdef CSI_TX_BURST_STATS_EN
  logic [15:0] len_q;
  logic        burst_done;

  // A burst completes when the lane leaves HS-trail, whichever state it leaves from.
  assign burst_done = ((state_q == S_TRAIL) && (cnt_q == 8'd0)) ||
                      ((state_q == S_DATA) && !in_valid && (LD_TRAIL == 8'd0));

  always_ff @(posedge byte_clock) begin
    if (!reset_n) begin
      len_q     <= 16'd0;
      burst_cnt <= 16'd0;
      last_len  <= 16'd0;
    end else begin
      if (state_q == S_IDLE) begin
        len_q <= 16'd0;
      end else if (in_ready && in_valid) begin
        len_q <= len_q + 16'd1;
      end
      if (burst_done) begin
        burst_cnt <= burst_cnt + 16'd1;
        last_len  <= len_q;
      end
    end
  end
`endif

endmodule
